// File: rtl/mc_bus_scheduler.sv
// Round-robin, packet-locked arbiter for the PE-array multicast bus.
// A granted packet owns the bus until its last beat; bus outputs are registered.
module mc_bus_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int GW         = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*ID_WIDTH-1:0]    req_id,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [ID_WIDTH-1:0]            bus_source_id,
  output logic [DATA_WIDTH-1:0]          bus_data,
  output logic                           bus_data_valid,
  output logic [GW-1:0]                  grant_idx,
  output logic                           busy
);

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  localparam int            SW       = GW + 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [GW-1:0]         ptr_q, ptr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [ID_WIDTH-1:0]   src_q, src_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic                  found;
  logic [GW-1:0]         winner;
  logic [SW-1:0]         cand;
  logic                  accept;

  // Wrapping search from ptr; the extra bit in cand lets NUM_REQ be a non-power-of-2.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + SW'(k);
      if (cand >= SW'(NUM_REQ)) cand = cand - SW'(NUM_REQ);
      if (!found && req_valid[cand[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand[GW-1:0];
      end
    end
  end

  // Handshake: a beat moves when req_valid and req_ready of the granted requester are
  // both high at a rising edge; ready is offered only in XFER, with ce high, outside reset.
  always_comb begin
    req_ready = '0;
    if (!rst && ce && state_q == S_XFER) req_ready[grant_q] = 1'b1;
  end

  assign accept = req_valid[grant_q] & req_ready[grant_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    src_d   = src_q;
    data_d  = '0;
    valid_d = 1'b0;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            grant_d = winner;
            src_d   = req_id[winner*ID_WIDTH +: ID_WIDTH];
            state_d = S_XFER;
          end
        end
        S_XFER: begin
          if (accept) begin
            data_d  = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
            valid_d = 1'b1;
            if (req_last[grant_q]) begin
              state_d = S_IDLE;
              ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + GW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      src_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      src_q   <= src_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus_source_id  = src_q;
  assign bus_data       = data_q;
  assign bus_data_valid = valid_q;
  assign grant_idx      = grant_q;
  assign busy           = (state_q == S_XFER);

endmodule

// File: tb/tb_mc_bus_scheduler.sv
// Bench for mc_bus_scheduler: per-requester packet queues drive the ports, and a
// transaction-level model of the arbitration rules predicts every bus cycle.
module tb_mc_bus_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 8;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ce  = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_last = '0;
  logic [N*IW-1:0] req_id = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [IW-1:0]   bus_source_id;
  logic [DW-1:0]   bus_data;
  logic            bus_data_valid;
  logic [GW-1:0]   grant_idx;
  logic            busy;

  mc_bus_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_id(req_id), .req_data(req_data),
    .bus_source_id(bus_source_id), .bus_data(bus_data),
    .bus_data_valid(bus_data_valid), .grant_idx(grant_idx), .busy(busy)
  );

  // ---------------- clock / timeout ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus and model state ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    bit            last;
    int            gap;
  } beat_t;

  beat_t         beats_q[N][$];
  logic [DW-1:0] exp_q[$];
  int            dut_log[$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            vprob    = 100;
  bit            chk_en   = 1'b0;
  bit            prev_busy = 1'b0;

  bit            m_busy = 1'b0;
  int            m_ptr = 0;
  int            m_grant = 0;
  logic [IW-1:0] m_src = '0;
  bit            m_exp_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_pkt(input int r, input int n, input logic [DW-1:0] base,
                         input logic [IW-1:0] id, input int first_gap);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + DW'(k);
      b.id   = (k == 0) ? id : IW'($urandom);
      b.last = (k == n - 1);
      b.gap  = (k == 0) ? first_gap : 0;
      beats_q[r].push_back(b);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += beats_q[i].size();
    return s + (m_busy ? 1 : 0);
  endfunction

  task automatic drive_requesters();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = 1'b0;
      req_last[i]            = 1'($urandom);
      req_id[i*IW +: IW]     = IW'($urandom);
      req_data[i*DW +: DW]   = DW'($urandom);
      if (beats_q[i].size() > 0) begin
        b = beats_q[i][0];
        if (b.gap > 0) begin
          b.gap--;
          beats_q[i][0] = b;
        end else begin
          req_valid[i]         = ($urandom_range(99) < vprob);
          req_last[i]          = b.last;
          req_id[i*IW +: IW]   = b.id;
          req_data[i*DW +: DW] = b.data;
        end
      end
    end
  endtask

  // Applies the arbitration rules to the inputs about to be sampled at the next edge.
  task automatic model_edge();
    beat_t b;
    bit    done;
    bit    found;
    int    w;
    if (rst) begin
      if (m_busy) begin
        done = 1'b0;
        while (!done && beats_q[m_grant].size() > 0) begin
          b    = beats_q[m_grant].pop_front();
          done = b.last;
        end
      end
      m_busy = 1'b0; m_ptr = 0; m_grant = 0; m_src = '0; m_exp_valid = 1'b0;
      exp_q.delete();
    end else if (!ce) begin
      m_exp_valid = 1'b0;
    end else if (!m_busy) begin
      m_exp_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        w = (m_ptr + k) % N;
        if (!found && req_valid[w]) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_grant = w;
          m_src   = req_id[w*IW +: IW];
        end
      end
    end else if (req_valid[m_grant]) begin
      b = beats_q[m_grant].pop_front();
      exp_q.push_back(b.data);
      m_exp_valid = 1'b1;
      if (b.last) begin
        m_busy = 1'b0;
        m_ptr  = (m_grant + 1) % N;
      end
    end else begin
      m_exp_valid = 1'b0;
    end
  endtask

  // One clock: check outputs of the previous edge, drive new inputs, predict the next edge.
  task automatic step(input bit r, input bit c);
    logic [DW-1:0] exp_d;
    logic [N-1:0]  exp_rdy;
    @(negedge clk);
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("grant_idx", 32'(grant_idx), 32'(m_grant));
      check("bus_source_id", 32'(bus_source_id), 32'(m_src));
      check("bus_data_valid", 32'(bus_data_valid), 32'(m_exp_valid));
      if (m_exp_valid) begin
        exp_d = exp_q.pop_front();
        check("bus_data", 32'(bus_data), 32'(exp_d));
      end else begin
        check("bus_data_idle", 32'(bus_data), 32'd0);
      end
      if (busy && !prev_busy) dut_log.push_back(int'(grant_idx));
      prev_busy = busy;
    end
    rst = r;
    ce  = c;
    drive_requesters();
    #1;
    exp_rdy = '0;
    if (!rst && ce && m_busy) exp_rdy[m_grant] = 1'b1;
    if (chk_en || rst) check("req_ready", 32'(req_ready), 32'(exp_rdy));
    model_edge();
    if (r) chk_en = 1'b1;
  endtask

  task automatic run(input int max_cycles, input int ce_pct, input int rst_permil);
    int cyc = 0;
    while (pending() > 0 && cyc < max_cycles) begin
      step($urandom_range(999) < rst_permil, $urandom_range(99) < ce_pct);
      cyc++;
    end
    check("drain_pending", 32'(pending()), 32'd0);
    step(1'b0, 1'b1);
  endtask

  task automatic check_log(input string tag, input int e0, input int e1, input int e2, input int n);
    int exp_a[3];
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2;
    check({tag, "_min_grants"}, 32'(dut_log.size() >= n), 32'd1);
    for (int k = 0; k < n; k++)
      if (k < dut_log.size()) check(tag, 32'(dut_log[k]), 32'(exp_a[k]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    beat_t b;

    // Reset held 2 cycles with every requester valid.
    add_pkt(0, 2, 16'h1000, 8'h10, 0);
    add_pkt(0, 2, 16'h1100, 8'h10, 0);
    add_pkt(1, 2, 16'h2000, 8'h11, 0);
    add_pkt(2, 2, 16'h3000, 8'h12, 0);
    add_pkt(3, 2, 16'h4000, 8'h13, 0);
    vprob = 100;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Round-robin fairness: grant order 0,1,2,3,0.
    dut_log.delete();
    run(200, 100, 0);
    check("rr_count", 32'(dut_log.size()), 32'd5);
    check_log("rr_order_a", 0, 1, 2, 3);
    if (dut_log.size() >= 5) begin
      check("rr_order_3", 32'(dut_log[3]), 32'd3);
      check("rr_order_4", 32'(dut_log[4]), 32'd0);
    end

    // Packet lock: req 2 owns the bus while 0 and 1 raise valid; ptr then at 3.
    add_pkt(2, 4, 16'hA000, 8'h22, 0);
    add_pkt(0, 2, 16'h5000, 8'h30, 2);
    add_pkt(1, 2, 16'h6000, 8'h31, 2);
    dut_log.delete();
    run(200, 100, 0);
    check_log("lock_order", 2, 0, 1, 3);

    // Mid-packet gap: req 1 drops valid for 3 cycles before its third beat.
    add_pkt(1, 4, 16'h7000, 8'h44, 0);
    b = beats_q[1][2];
    b.gap = 3;
    beats_q[1][2] = b;
    run(200, 100, 0);

    // Stall: ce low for 2 cycles after two beats of a 4-beat packet.
    add_pkt(0, 4, 16'hB000, 8'h55, 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run(200, 100, 0);

    // Reset at the third beat of a 4-beat packet from req 3; arbitration restarts at 0.
    add_pkt(3, 4, 16'hC000, 8'h66, 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    add_pkt(1, 1, 16'hD000, 8'h77, 0);
    add_pkt(3, 1, 16'hD300, 8'h78, 0);
    dut_log.delete();
    run(200, 100, 0);
    check_log("post_reset_order", 1, 3, 0, 2);

    // Randomized traffic with random valid drops, stalls and occasional resets.
    for (int round = 0; round < 12; round++) begin
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++)
          add_pkt(i, $urandom_range(1, 4), DW'($urandom), IW'($urandom), $urandom_range(0, 2));
      end
      vprob = $urandom_range(50, 100);
      run(2000, 85, 5);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
